pipe_stage_reg: RTL

Parametrised inter-stage pipeline register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries an opaque data payload and a control bundle between two stages using valid/ready handshaking. A synchronous flush kills the stage's contents and clears selected control bits to form a bubble. An optional skid buffer fully registers the backpressure path.

---
 rtl/pipe_stage_reg.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable inter-stage pipeline register carrying a data
// payload and a control bundle under valid/ready handshaking.
//
// Handshake: a transfer in happens on a cycle where in_valid && in_ready; a
// transfer out happens on a cycle where out_valid && out_ready. Neither side
// may make its valid depend on the other side's ready.
//
// Priority: reset, then flush, then normal transfers. Flush empties the stage
// and clears the control bits selected by CTRL_KILL_MASK so a bubble never
// carries an asserted write enable; out_data and the unmasked control bits hold.
//
// Optional feature macro: PIPE_STAGE_REG_SKID_EN
//   defined   : two-entry skid buffer, registered in_ready, occupancy 0..2
//   undefined : single register, combinational in_ready, occupancy 0..1
module pipe_stage_reg #(
  parameter int unsigned              DATA_W         = 96,
  parameter int unsigned              CTRL_W         = 8,
  parameter logic [CTRL_W-1:0]        CTRL_KILL_MASK = {CTRL_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // Control bits that survive a flush or drain.
  localparam logic [CTRL_W-1:0] KEEP_MASK = ~CTRL_KILL_MASK;

  logic              w_xfer_in;
  logic              w_xfer_out;
  logic [DATA_W-1:0] r_out_data;
  logic [CTRL_W-1:0] r_out_ctrl;

  assign out_data = r_out_data;
  assign out_ctrl = r_out_ctrl;

`ifdef PIPE_STAGE_REG_SKID_EN

  // EMPTY: nothing held; ONE: output register only; FULL: output + skid.
  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } skid_state_t;

  skid_state_t       r_state;
  skid_state_t       w_state_nxt;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              w_out_valid;
  logic              w_load_out_in;
  logic              w_load_out_skid;
  logic              w_load_skid;
  logic              w_bubble;

  // in_ready comes from a register; reset and flush still gate it at once.
  assign in_ready    = r_in_ready && !reset && !flush;
  assign w_out_valid = (r_state != S_EMPTY);
  assign out_valid   = w_out_valid;
  assign occupancy   = r_state;
  assign w_xfer_in   = in_valid && in_ready;
  assign w_xfer_out  = w_out_valid && out_ready;

  // State register plus registered in_ready (not FULL next cycle).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_FULL);
    end
  end

  // Next-state and datapath load selects from the handshake outcome.
  always_comb begin
    w_state_nxt     = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    w_bubble        = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_xfer_in) begin
          w_state_nxt   = S_ONE;
          w_load_out_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_xfer_in && w_xfer_out) begin
          w_load_out_in = 1'b1;
        end else if (w_xfer_in) begin
          w_state_nxt = S_FULL;
          w_load_skid = 1'b1;
        end else if (w_xfer_out) begin
          w_state_nxt = S_EMPTY;
          w_bubble    = 1'b1;
        end
      end
      S_FULL: begin
        // FULL never accepts input, so only a drain of the output matters.
        if (w_xfer_out) begin
          w_state_nxt     = S_ONE;
          w_load_out_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // Output and skid payload registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_ctrl  <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (flush) begin
      r_out_ctrl <= r_out_ctrl & KEEP_MASK;
    end else begin
      if (w_load_out_in) begin
        r_out_data <= in_data;
        r_out_ctrl <= in_ctrl;
      end else if (w_load_out_skid) begin
        r_out_data <= r_skid_data;
        r_out_ctrl <= r_skid_ctrl;
      end else if (w_bubble) begin
        r_out_ctrl <= r_out_ctrl & KEEP_MASK;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
        r_skid_ctrl <= in_ctrl;
      end
    end
  end

`else

  logic r_out_valid;

  // Accept when empty or when the held entry leaves this same cycle.
  assign in_ready   = !reset && !flush && (!r_out_valid || out_ready);
  assign out_valid  = r_out_valid;
  assign occupancy  = {1'b0, r_out_valid};
  assign w_xfer_in  = in_valid && in_ready;
  assign w_xfer_out = r_out_valid && out_ready;

  // Single output register: load on transfer in, bubble on drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ctrl  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= r_out_ctrl & KEEP_MASK;
    end else if (w_xfer_in) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data;
      r_out_ctrl  <= in_ctrl;
    end else if (w_xfer_out) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= r_out_ctrl & KEEP_MASK;
    end
  end

`endif

endmodule
